data_mem_responder: RTL and testbench

Data-memory responder for the pipeline's MEM stage. It accepts one load/store request at a time over a valid/ready handshake, inserts a configurable number of wait states, and performs the access on its internal word array. It returns the result over a second valid/ready channel, so the MEM stage can stall on memory latency instead of assuming a single-cycle combinational memory.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/data_mem_responder_if.sv | 33 +++
 rtl/dmem_array.sv | 37 +++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg : shared types and constants for the data-memory responder
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int ADDR_LSB  = 2;
  localparam int NUM_LANES = 4;

  // Reason codes the MEM stage uses to classify a failed access
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if : request/response channels between MEM stage and responder
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface data_mem_responder_if;
  import dmem_pkg::*;

  logic                 inReqValid;
  logic                 inReqWrite;
  logic [31:0]          inReqAddress;
  logic [31:0]          inReqWriteData;
  logic [NUM_LANES-1:0] inReqByteEn;
  logic                 outReqReady;
  logic                 outRespValid;
  logic [31:0]          outRespData;
  logic                 outRespError;
  logic                 inRespReady;

  modport master (
    output inReqValid, inReqWrite, inReqAddress, inReqWriteData, inReqByteEn, inRespReady,
    input  outReqReady, outRespValid, outRespData, outRespError
  );

  modport slave (
    input  inReqValid, inReqWrite, inReqAddress, inReqWriteData, inReqByteEn, inRespReady,
    output outReqReady, outRespValid, outRespData, outRespError
  );

endinterface

`default_nettype wire

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array : single-port word RAM, byte-lane write enable, registered read
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [NUM_LANES-1:0]           byte_en,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read data only moves on an enabled access, so it holds through a stalled response
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (byte_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder : MEM-stage load/store responder with programmable wait states
// Option   : define DMEM_MISALIGN_CHECK_EN to reject addresses with address[1:0] != 0
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic                 access;

  logic                 req_write;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic [NUM_LANES-1:0] req_be;

  logic                 acc_write;
  logic [31:0]          acc_addr;
  logic [31:0]          acc_wdata;
  logic [NUM_LANES-1:0] acc_be;
  logic [1:0]           acc_err;

  logic                 resp_valid;
  logic                 resp_error;
  logic                 resp_load;
  logic [31:0]          ram_rdata;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.inReqValid) begin
          if (WAIT_STATES == 0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          access   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.inRespReady) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Zero wait states access on the accept edge itself, so the live request is used there
  always_comb begin
    acc_write = req_write;
    acc_addr  = req_addr;
    acc_wdata = req_wdata;
    acc_be    = req_be;
    if (state == IDLE) begin
      acc_write = bus.inReqWrite;
      acc_addr  = bus.inReqAddress;
      acc_wdata = bus.inReqWriteData;
      acc_be    = bus.inReqByteEn;
    end
  end

  always_comb begin
    acc_err = ERR_NONE;
    if ((acc_addr >> (IDX_W + ADDR_LSB)) != 32'd0) begin
      acc_err = ERR_RANGE;
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    else if (acc_addr[ADDR_LSB-1:0] != '0) begin
      acc_err = ERR_MISALIGN;
    end
`endif
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .en      (access && (acc_err == ERR_NONE) && reset),
    .we      (acc_write),
    .idx     (acc_addr[IDX_W+ADDR_LSB-1:ADDR_LSB]),
    .byte_en (acc_be),
    .wdata   (acc_wdata),
    .rdata   (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_write  <= 1'b0;
      req_addr   <= 32'd0;
      req_wdata  <= 32'd0;
      req_be     <= '0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_load  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && bus.inReqValid) begin
        req_write <= bus.inReqWrite;
        req_addr  <= bus.inReqAddress;
        req_wdata <= bus.inReqWriteData;
        req_be    <= bus.inReqByteEn;
      end
      if (access) begin
        resp_valid <= 1'b1;
        resp_error <= (acc_err != ERR_NONE);
        resp_load  <= !acc_write && (acc_err == ERR_NONE);
      end else if (state == RESP && bus.inRespReady) begin
        resp_valid <= 1'b0;
        resp_error <= 1'b0;
        resp_load  <= 1'b0;
      end
    end
  end

  assign bus.outReqReady  = (state == IDLE);
  assign bus.outRespValid = resp_valid;
  assign bus.outRespError = resp_error;
  assign bus.outRespData  = resp_load ? ram_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder : directed self-checking bench (WAIT_STATES=2 and 0 instances)
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_responder_if bif ();
  data_mem_responder_if bif0 ();

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif0.slave)
  );

  // Drive a request on the WAIT_STATES=2 instance; returns just after the accept edge
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    int guard = 0;
    @(negedge clk);
    bif.inReqValid     = 1'b1;
    bif.inReqWrite     = wr;
    bif.inReqAddress   = addr;
    bif.inReqWriteData = wd;
    bif.inReqByteEn    = be;
    while (bif.outReqReady !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: outReqReady=%b never rose, required 1", bif.outReqReady);
    end
    @(posedge clk);
    #1;
    bif.inReqValid     = 1'b0;
    bif.inReqWrite     = ~wr;
    bif.inReqAddress   = 32'hFFFF_FFFC;
    bif.inReqWriteData = 32'h0BAD_0BAD;
    bif.inReqByteEn    = 4'hF;
  endtask

  // Wait for the response (cycles counted from the accept edge), optionally complete it
  task automatic collect(input bit hs, output logic [31:0] data, output logic err, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bif.outRespValid !== 1'b1 && lat < 100);
    data = bif.outRespData;
    err  = bif.outRespError;
    if (hs) begin
      bif.inRespReady = 1'b1;
      @(posedge clk);
      #1;
      bif.inRespReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bif.outReqReady !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", bif.outReqReady);
    end
    n_checks++;
    if (bif.outRespValid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b required 0", bif.outRespValid);
    end
    n_checks++;
    if (bif.outRespData !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: got %h required 00000000", bif.outRespData);
    end
    n_checks++;
    if (bif.outRespError !== 1'b0) begin
      n_fail++; $display("FAIL reset_error: got %b required 0", bif.outRespError);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bif.outReqReady !== 1'b1 || bif.outRespValid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: ready=%b valid=%b required 1/0", bif.outReqReady, bif.outRespValid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL store_latency: got %0d required 3", lat); end
    n_checks++;
    if (d !== 32'd0 || e !== 1'b0) begin
      n_fail++; $display("FAIL store_resp: data=%h err=%b required 00000000/0", d, e);
    end
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL load_latency: got %0d required 3", lat); end
    n_checks++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      n_fail++; $display("FAIL load_data: data=%h err=%b required deadbeef/0", d, e);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 32'h20, 32'h1122_3344, 4'hF);
    collect(1'b1, d, e, lat);
    issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
    collect(1'b1, d, e, lat);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'h11BB_33DD || e !== 1'b0) begin
      n_fail++; $display("FAIL byte_lane_merge: data=%h err=%b required 11bb33dd/0", d, e);
    end
    issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'd0 || e !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL zero_lane_store: data=%h err=%b lat=%0d required 0/0/3", d, e, lat);
    end
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'h11BB_33DD) begin
      n_fail++; $display("FAIL zero_lane_unchanged: got %h required 11bb33dd", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, d; logic e0, e; int lat;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    bif.inReqValid     = 1'b1;
    bif.inReqWrite     = 1'b0;
    bif.inReqAddress   = 32'h20;
    bif.inReqWriteData = 32'h0;
    bif.inReqByteEn    = 4'h0;
    collect(1'b0, d0, e0, lat);
    n_checks++;
    if (d0 !== 32'hDEAD_BEEF || e0 !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL bp_first_resp: data=%h err=%b lat=%0d required deadbeef/0/3", d0, e0, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bif.outRespValid !== 1'b1 || bif.outRespData !== 32'hDEAD_BEEF ||
          bif.outRespError !== 1'b0 || bif.outReqReady !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h err=%b ready=%b required 1/deadbeef/0/0",
                 i, bif.outRespValid, bif.outRespData, bif.outRespError, bif.outReqReady);
      end
    end
    bif.inRespReady = 1'b1;
    @(posedge clk);
    #1;
    bif.inRespReady = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bif.outReqReady !== 1'b1 || bif.outRespValid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_handshake: ready=%b valid=%b required 1/0", bif.outReqReady, bif.outRespValid);
    end
    @(posedge clk);
    #1;
    bif.inReqValid = 1'b0;
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'h11BB_33DD || e !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL bp_second_resp: data=%h err=%b lat=%0d required 11bb33dd/0/3", d, e, lat);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 32'h0, 32'h5566_7788, 4'hF);
    collect(1'b1, d, e, lat);
    issue(1'b0, 32'h400, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'd0 || e !== 1'b1 || lat != 3) begin
      n_fail++; $display("FAIL oor_load: data=%h err=%b lat=%0d required 0/1/3", d, e, lat);
    end
    issue(1'b1, 32'h400, 32'h9999_9999, 4'hF);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'd0 || e !== 1'b1) begin
      n_fail++; $display("FAIL oor_store: data=%h err=%b required 0/1", d, e);
    end
    issue(1'b0, 32'h0, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'h5566_7788 || e !== 1'b0) begin
      n_fail++; $display("FAIL oor_word0_kept: data=%h err=%b required 55667788/0", d, e);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] d; logic e; int lat;
    issue(1'b0, 32'h13, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (d !== 32'd0 || e !== 1'b1 || lat != 3) begin
      n_fail++; $display("FAIL misalign_load: data=%h err=%b lat=%0d required 0/1/3", d, e, lat);
    end
`else
    if (d !== 32'hDEAD_BEEF || e !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL misalign_load: data=%h err=%b lat=%0d required deadbeef/0/3", d, e, lat);
    end
`endif
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d; logic e; int lat;
    issue(1'b1, 32'h30, 32'h0, 4'hF);
    collect(1'b1, d, e, lat);
    issue(1'b1, 32'h30, 32'h1234_5678, 4'hF);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bif.outReqReady !== 1'b1 || bif.outRespValid !== 1'b0 ||
        bif.outRespData !== 32'd0 || bif.outRespError !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_reset_outputs: ready=%b valid=%b data=%h err=%b required 1/0/0/0",
               bif.outReqReady, bif.outRespValid, bif.outRespData, bif.outRespError);
    end
    issue(1'b0, 32'h30, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'd0 || e !== 1'b0 || lat != 3) begin
      n_fail++; $display("FAIL dropped_store: data=%h err=%b lat=%0d required 0/0/3", d, e, lat);
    end
    issue(1'b1, 32'h34, 32'hCAFE_F00D, 4'hF);
    collect(1'b0, d, e, lat);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bif.outRespValid !== 1'b0) begin
      n_fail++; $display("FAIL resp_discarded: valid=%b required 0", bif.outRespValid);
    end
    reset = 1'b1;
    issue(1'b0, 32'h34, 32'h0, 4'h0);
    collect(1'b1, d, e, lat);
    n_checks++;
    if (d !== 32'hCAFE_F00D || e !== 1'b0) begin
      n_fail++; $display("FAIL committed_store: data=%h err=%b required cafef00d/0", d, e);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] d; logic e; int lat;
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      bif0.inReqValid     = 1'b1;
      bif0.inReqWrite     = (op == 0);
      bif0.inReqAddress   = 32'h8;
      bif0.inReqWriteData = 32'hA5A5_A5A5;
      bif0.inReqByteEn    = 4'hF;
      @(posedge clk);
      #1;
      bif0.inReqValid     = 1'b0;
      bif0.inReqAddress   = 32'hFFFF_FFFC;
      bif0.inReqWriteData = 32'h0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (bif0.outRespValid !== 1'b1 && lat < 20);
      d = bif0.outRespData;
      e = bif0.outRespError;
      n_checks++;
      if (lat != 1 || e !== 1'b0 || d !== ((op == 0) ? 32'd0 : 32'hA5A5_A5A5)) begin
        n_fail++; $display("FAIL zero_wait_op%0d: data=%h err=%b lat=%0d required %h/0/1",
                           op, d, e, lat, (op == 0) ? 32'd0 : 32'hA5A5_A5A5);
      end
      bif0.inRespReady = 1'b1;
      @(posedge clk);
      #1;
      bif0.inRespReady = 1'b0;
    end
  endtask

  initial begin
    bif.inReqValid      = 1'b0;
    bif.inReqWrite      = 1'b0;
    bif.inReqAddress    = 32'd0;
    bif.inReqWriteData  = 32'd0;
    bif.inReqByteEn     = 4'h0;
    bif.inRespReady     = 1'b0;
    bif0.inReqValid     = 1'b0;
    bif0.inReqWrite     = 1'b0;
    bif0.inReqAddress   = 32'd0;
    bif0.inReqWriteData = 32'd0;
    bif0.inReqByteEn    = 4'h0;
    bif0.inRespReady    = 1'b0;

    test_reset();
    test_store_load();
    test_byte_lanes();
    test_backpressure();
    test_out_of_range();
    test_misalign();
    test_reset_mid_op();
    test_zero_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
